// File: rtl/ansi_vram_writer.sv
// ANSI/VT100 byte-stream decoder: parses printable text, CR/LF, CUP, SGR and
// ED(2) and writes 16-bit character cells into VRAM through a master port.
module ansi_vram_writer #(
  parameter int ROWS     = 20,
  parameter int COLS     = 64,
  parameter int ROW_BASE = 1,
  parameter int COL_BASE = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  input  logic        VRAM_LOCK,
  output logic        VRAM_ENABLE,
  output logic        VRAM_WRITE,
  output logic [10:0] VRAM_ADDR,
  output logic [15:0] VRAM_DATA_W,
  output logic        SIG_BUSY,
  output logic        ERR_OVERRUN
);

  typedef enum logic [2:0] {S_IDLE, S_ESC, S_CSI, S_WRITE, S_CLEAR} state_t;

  localparam logic [7:0]  ATTR_RST  = 8'h38;
  localparam logic [10:0] LAST_ADDR = 11'((ROWS - 1) * 64 + 63);

  state_t      r_state, w_state_nxt;
  logic        r_hold_valid, w_hold_valid_nxt;
  logic [7:0]  r_hold_data, w_hold_data_nxt;
  logic [7:0]  r_char, w_char_nxt;
  logic [4:0]  r_row, w_row_nxt;
  logic [5:0]  r_col, w_col_nxt;
  logic [7:0]  r_attr, w_attr_nxt;
  logic [7:0]  r_attr_sh, w_attr_sh_nxt;
  logic [6:0]  r_acc, w_acc_nxt;
  logic [6:0]  r_p0, w_p0_nxt;
  logic [6:0]  r_p1, w_p1_nxt;
  logic        r_idx, w_idx_nxt;
  logic        r_priv, w_priv_nxt;
  logic [10:0] r_clr_addr, w_clr_addr_nxt;
  logic        r_overrun, w_overrun_nxt;

  logic        w_consume;
  logic        w_wr;
  logic [9:0]  w_acc_calc;
  logic [6:0]  w_cur_p0, w_cur_p1;

  function automatic logic [7:0] sgr_apply(input logic [7:0] a, input logic [6:0] v);
    logic [7:0] r;
    r = a;
    if (v == 7'd0)                        r = ATTR_RST;
    else if (v == 7'd1)                   r[7] = 1'b1;
    else if (v == 7'd4)                   r[6] = 1'b1;
    else if (v >= 7'd30 && v <= 7'd37)    r[5:3] = 3'(v - 7'd30);
    else if (v >= 7'd40 && v <= 7'd47)    r[2:0] = 3'(v - 7'd40);
    return r;
  endfunction

  function automatic logic [4:0] pos_row(input logic [6:0] v);
    int t;
    t = (v == 7'd0) ? 1 : int'(v);
    if (t > ROWS + ROW_BASE - 1) t = ROWS + ROW_BASE - 1;
    t = t - ROW_BASE;
    if (t < 0) t = 0;
    return 5'(t);
  endfunction

  function automatic logic [5:0] pos_col(input logic [6:0] v);
    int t;
    t = (v == 7'd0) ? 1 : int'(v);
    if (t > COLS + COL_BASE - 1) t = COLS + COL_BASE - 1;
    t = t - COL_BASE;
    if (t < 0) t = 0;
    return 6'(t);
  endfunction

  // The parser drains the hold register only in IDLE/ESC/CSI; WRITE and
  // CLEAR leave it full, which is what makes a second byte an overrun.
  assign w_consume  = r_hold_valid && (r_state inside {S_IDLE, S_ESC, S_CSI});
  assign w_wr       = (r_state == S_WRITE || r_state == S_CLEAR) && !VRAM_LOCK;
  assign w_acc_calc = {3'b000, r_acc} * 10'd10 + {6'b000000, r_hold_data[3:0]};
  assign w_cur_p0   = r_idx ? r_p0  : r_acc;
  assign w_cur_p1   = r_idx ? r_acc : r_p1;

  assign VRAM_ENABLE = w_wr;
  assign VRAM_WRITE  = w_wr;
  assign VRAM_ADDR   = !w_wr ? '0 : (r_state == S_WRITE) ? {r_row, r_col} : r_clr_addr;
  assign VRAM_DATA_W = (w_wr && r_state == S_WRITE) ? {r_attr, r_char} : '0;
  assign SIG_BUSY    = r_hold_valid || r_state == S_WRITE || r_state == S_CLEAR;
  assign ERR_OVERRUN = r_overrun;

  always_comb begin
    w_state_nxt      = r_state;
    w_hold_valid_nxt = r_hold_valid && !w_consume;
    w_hold_data_nxt  = r_hold_data;
    w_char_nxt       = r_char;
    w_row_nxt        = r_row;
    w_col_nxt        = r_col;
    w_attr_nxt       = r_attr;
    w_attr_sh_nxt    = r_attr_sh;
    w_acc_nxt        = r_acc;
    w_p0_nxt         = r_p0;
    w_p1_nxt         = r_p1;
    w_idx_nxt        = r_idx;
    w_priv_nxt       = r_priv;
    w_clr_addr_nxt   = r_clr_addr;
    w_overrun_nxt    = r_overrun;

    if (RX_VALID) begin
      if (!r_hold_valid || w_consume) begin
        w_hold_valid_nxt = 1'b1;
        w_hold_data_nxt  = RX_DATA;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: if (w_consume) begin
        if (r_hold_data == 8'h1B) begin
          w_state_nxt = S_ESC;
        end else if (r_hold_data >= 8'h20 && r_hold_data <= 8'h7E) begin
          w_char_nxt  = r_hold_data;
          w_state_nxt = S_WRITE;
        end else if (r_hold_data == 8'h0D) begin
          w_col_nxt = '0;
        end else if (r_hold_data == 8'h0A) begin
          w_row_nxt = (r_row == 5'(ROWS - 1)) ? '0 : r_row + 5'd1;
        end
      end
      S_ESC: if (w_consume) begin
        w_state_nxt = S_IDLE;
        if (r_hold_data == 8'h5B) begin
          w_state_nxt   = S_CSI;
          w_p0_nxt      = '0;
          w_p1_nxt      = '0;
          w_acc_nxt     = '0;
          w_idx_nxt     = 1'b0;
          w_priv_nxt    = 1'b0;
          w_attr_sh_nxt = r_attr;
        end
      end
      S_CSI: if (w_consume) begin
        // SGR parameters fold into a shadow attribute, committed only on 'm'
        // so that ';' inside a cursor-position sequence cannot alter attr.
        if (r_hold_data >= 8'h30 && r_hold_data <= 8'h39) begin
          w_acc_nxt = (w_acc_calc > 10'd99) ? 7'd99 : w_acc_calc[6:0];
        end else if (r_hold_data == 8'h3B) begin
          if (r_idx) w_p1_nxt = r_acc;
          else       w_p0_nxt = r_acc;
          w_attr_sh_nxt = sgr_apply(r_attr_sh, r_acc);
          w_idx_nxt     = 1'b1;
          w_acc_nxt     = '0;
        end else if (r_hold_data == 8'h3F) begin
          w_priv_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          if (!r_priv) begin
            if (r_hold_data == 8'h48) begin
              w_row_nxt = pos_row(w_cur_p0);
              w_col_nxt = pos_col(w_cur_p1);
            end else if (r_hold_data == 8'h6D) begin
              w_attr_nxt = sgr_apply(r_attr_sh, r_acc);
            end else if (r_hold_data == 8'h4A && w_cur_p0 == 7'd2) begin
              w_state_nxt    = S_CLEAR;
              w_clr_addr_nxt = '0;
            end
          end
        end
      end
      S_WRITE: if (w_wr) begin
        w_state_nxt = S_IDLE;
        if (r_col == 6'(COLS - 1)) begin
          w_col_nxt = '0;
          w_row_nxt = (r_row == 5'(ROWS - 1)) ? '0 : r_row + 5'd1;
        end else begin
          w_col_nxt = r_col + 6'd1;
        end
      end
      S_CLEAR: if (w_wr) begin
        if (r_clr_addr == LAST_ADDR) w_state_nxt = S_IDLE;
        else                         w_clr_addr_nxt = r_clr_addr + 11'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_char       <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_attr       <= ATTR_RST;
      r_attr_sh    <= ATTR_RST;
      r_acc        <= '0;
      r_p0         <= '0;
      r_p1         <= '0;
      r_idx        <= 1'b0;
      r_priv       <= 1'b0;
      r_clr_addr   <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_hold_data  <= w_hold_data_nxt;
      r_char       <= w_char_nxt;
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_attr       <= w_attr_nxt;
      r_attr_sh    <= w_attr_sh_nxt;
      r_acc        <= w_acc_nxt;
      r_p0         <= w_p0_nxt;
      r_p1         <= w_p1_nxt;
      r_idx        <= w_idx_nxt;
      r_priv       <= w_priv_nxt;
      r_clr_addr   <= w_clr_addr_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

endmodule
